// File: rtl/axil_reg_responder.sv
// AXI4-Lite register responder: turns control-port writes/reads into one-cycle strobes to user registers.
// Latency: write strobe and bvalid one cycle after both AW and W are held; rvalid 3 cycles after the AR handshake.
// Backpressure: awready/wready low while an address/data is held or bvalid is pending; arready only in read IDLE.
//
// Ports:
//   clk, reset                  - single rising-edge clock, synchronous active-high reset
//   control_aw*/w*/b*           - AXI4-Lite write address, write data and write response channels
//   control_ar*/r*              - AXI4-Lite read address and read data channels
//   reg_wr_en/idx/data          - one-cycle write strobe to user logic (word index = addr[ADDR_W-1:2])
//   reg_rd_en/idx, reg_rd_data  - read strobe; user logic returns reg_rd_data one cycle after reg_rd_en
//
// Build option: define AXIL_RESP_SLVERR_EN to report index >= NUM_REGS as SLVERR with no strobe and rdata = 0.
// Without it the index wraps modulo 2^(ADDR_W-2), every access strobes and every response is OKAY.
module axil_reg_responder #(
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] control_awaddr,
    input  logic              control_awvalid,
    output logic              control_awready,
    input  logic [31:0]       control_wdata,
    input  logic              control_wvalid,
    output logic              control_wready,
    output logic [1:0]        control_bresp,
    output logic              control_bvalid,
    input  logic              control_bready,
    input  logic [ADDR_W-1:0] control_araddr,
    input  logic              control_arvalid,
    output logic              control_arready,
    output logic [31:0]       control_rdata,
    output logic [1:0]        control_rresp,
    output logic              control_rvalid,
    input  logic              control_rready,
    output logic              reg_wr_en,
    output logic [ADDR_W-3:0] reg_wr_idx,
    output logic [31:0]       reg_wr_data,
    output logic              reg_rd_en,
    output logic [ADDR_W-3:0] reg_rd_idx,
    input  logic [31:0]       reg_rd_data
);

    localparam int IDX_W = ADDR_W - 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STROBE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_RESP_SLVERR_EN
    localparam logic LP_SLVERR_EN = 1'b1;
`else
    localparam logic LP_SLVERR_EN = 1'b0;
`endif

    // One extra bit so NUM_REGS = 2^IDX_W is representable.
    localparam logic [IDX_W:0] LP_NUM_REGS = (IDX_W + 1)'(NUM_REGS);

    // Byte-lane bits of the address are ignored by design.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{control_awaddr[1:0], control_araddr[1:0]};

    // ---------------------------------------------------------------
    // Write path
    // ---------------------------------------------------------------
    logic             r_aw_held;
    logic             r_w_held;
    logic [IDX_W-1:0] r_aw_idx;
    logic [31:0]      r_wdata;
    logic             r_bvalid;
    logic [1:0]       r_bresp;
    logic             r_wr_en;
    logic [IDX_W-1:0] r_wr_idx;
    logic [31:0]      r_wr_data;

    logic             w_awready;
    logic             w_wready;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;
    logic [IDX_W-1:0] w_aw_idx_now;
    logic [31:0]      w_wdata_now;
    logic             w_wr_fire;
    logic             w_wr_err;

    assign w_awready = !r_aw_held && !r_bvalid;
    assign w_wready  = !r_w_held  && !r_bvalid;
    assign w_aw_hs   = control_awvalid && w_awready;
    assign w_w_hs    = control_wvalid  && w_wready;
    assign w_b_hs    = r_bvalid && control_bready;

    // Address/data may arrive this cycle or may already be held.
    assign w_aw_idx_now = r_aw_held ? r_aw_idx : control_awaddr[ADDR_W-1:2];
    assign w_wdata_now  = r_w_held  ? r_wdata  : control_wdata;

    // Completing the pair on this edge makes strobe and bvalid appear together next cycle;
    // r_bvalid blocks a retrigger while the response is outstanding.
    assign w_wr_fire = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
    assign w_wr_err  = LP_SLVERR_EN && ({1'b0, w_aw_idx_now} >= LP_NUM_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= control_awaddr[ADDR_W-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= control_wdata;
            end
            if (w_wr_fire) begin
                r_wr_en   <= !w_wr_err;
                r_wr_idx  <= w_aw_idx_now;
                r_wr_data <= w_wdata_now;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (w_b_hs) begin
                // Held flags stay set until here so awready/wready stay low for the whole transaction.
                r_bvalid  <= 1'b0;
                r_bresp   <= RESP_OKAY;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------
    logic [1:0]       r_rd_state;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_rd_err;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;

    logic             w_ar_err;

    assign w_ar_err = LP_SLVERR_EN && ({1'b0, control_araddr[ADDR_W-1:2]} >= LP_NUM_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= ST_IDLE;
            r_rd_idx   <= '0;
            r_rd_err   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                ST_IDLE: begin
                    if (control_arvalid) begin
                        r_rd_idx   <= control_araddr[ADDR_W-1:2];
                        r_rd_err   <= w_ar_err;
                        r_rd_state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    r_rd_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // User data is valid in the cycle after the strobe, i.e. this one.
                    r_rdata    <= r_rd_err ? 32'd0 : reg_rd_data;
                    r_rresp    <= r_rd_err ? RESP_SLVERR : RESP_OKAY;
                    r_rd_state <= ST_RESP;
                end
                default: begin
                    if (control_rready) begin
                        r_rd_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs: forced quiet while reset is high, so a transaction caught
    // mid-flight by reset never strobes or responds in the reset cycle.
    // ---------------------------------------------------------------
    assign control_awready = !reset && w_awready;
    assign control_wready  = !reset && w_wready;
    assign control_bvalid  = !reset && r_bvalid;
    assign control_bresp   = reset ? RESP_OKAY : r_bresp;

    assign control_arready = !reset && (r_rd_state == ST_IDLE);
    assign control_rvalid  = !reset && (r_rd_state == ST_RESP);
    assign control_rdata   = reset ? 32'd0 : r_rdata;
    assign control_rresp   = reset ? RESP_OKAY : r_rresp;

    assign reg_wr_en   = !reset && r_wr_en;
    assign reg_wr_idx  = reset ? '0 : r_wr_idx;
    assign reg_wr_data = reset ? 32'd0 : r_wr_data;

    assign reg_rd_en   = !reset && (r_rd_state == ST_STROBE) && !r_rd_err;
    assign reg_rd_idx  = reset ? '0 : r_rd_idx;

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder (ADDR_W=8, NUM_REGS=4).
// Inputs are driven 1 time unit after the rising edge; outputs are checked at the same point.
// Expectations for the out-of-range access follow the AXIL_RESP_SLVERR_EN build option.
module tb_axil_reg_responder;

`ifdef AXIL_RESP_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  control_awaddr;
    logic        control_awvalid;
    logic        control_awready;
    logic [31:0] control_wdata;
    logic        control_wvalid;
    logic        control_wready;
    logic [1:0]  control_bresp;
    logic        control_bvalid;
    logic        control_bready;
    logic [7:0]  control_araddr;
    logic        control_arvalid;
    logic        control_arready;
    logic [31:0] control_rdata;
    logic [1:0]  control_rresp;
    logic        control_rvalid;
    logic        control_rready;
    logic        reg_wr_en;
    logic [5:0]  reg_wr_idx;
    logic [31:0] reg_wr_data;
    logic        reg_rd_en;
    logic [5:0]  reg_rd_idx;
    logic [31:0] reg_rd_data;

    axil_reg_responder #(.ADDR_W(8), .NUM_REGS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .control_awaddr  (control_awaddr),
        .control_awvalid (control_awvalid),
        .control_awready (control_awready),
        .control_wdata   (control_wdata),
        .control_wvalid  (control_wvalid),
        .control_wready  (control_wready),
        .control_bresp   (control_bresp),
        .control_bvalid  (control_bvalid),
        .control_bready  (control_bready),
        .control_araddr  (control_araddr),
        .control_arvalid (control_arvalid),
        .control_arready (control_arready),
        .control_rdata   (control_rdata),
        .control_rresp   (control_rresp),
        .control_rvalid  (control_rvalid),
        .control_rready  (control_rready),
        .reg_wr_en       (reg_wr_en),
        .reg_wr_idx      (reg_wr_idx),
        .reg_wr_data     (reg_wr_data),
        .reg_rd_en       (reg_rd_en),
        .reg_rd_idx      (reg_rd_idx),
        .reg_rd_data     (reg_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int wr_strobes = 0;
    int rd_strobes = 0;
    int snap;

    // Strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) wr_strobes++;
        if (reg_rd_en === 1'b1) rd_strobes++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        control_awaddr = '0; control_awvalid = 1'b0;
        control_wdata = '0;  control_wvalid = 1'b0;
        control_bready = 1'b0;
        control_araddr = '0; control_arvalid = 1'b0;
        control_rready = 1'b0;
        reg_rd_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_ready", {29'd0, control_awready, control_wready, control_arready}, 32'd0);
        chk("rst_valid", {28'd0, control_bvalid, control_rvalid, reg_wr_en, reg_rd_en}, 32'd0);
        chk("rst_data", {control_rdata[29:0], control_bresp}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {29'd0, control_awready, control_wready, control_arready}, 32'd7);

        // AW and W in the same cycle
        control_awaddr = 8'h08; control_awvalid = 1'b1;
        control_wdata = 32'hDEADBEEF; control_wvalid = 1'b1;
        tick();
        control_awvalid = 1'b0; control_wvalid = 1'b0;
        chk("same_wr_en", {31'd0, reg_wr_en}, 32'd1);
        chk("same_wr_idx", {26'd0, reg_wr_idx}, 32'd2);
        chk("same_wr_data", reg_wr_data, 32'hDEADBEEF);
        chk("same_bvalid_bresp", {29'd0, control_bvalid, control_bresp}, 32'h4);
        tick();
        chk("same_strobe_one_cycle", {30'd0, reg_wr_en, control_bvalid}, 32'd1);
        control_bready = 1'b1;
        tick();
        control_bready = 1'b0;
        chk("same_b_done", {30'd0, control_bvalid, control_awready}, 32'd1);

        // W three cycles ahead of AW
        snap = wr_strobes;
        control_wdata = 32'h00000011; control_wvalid = 1'b1;
        tick();
        control_wvalid = 1'b0;
        chk("w_first_wready_drop", {31'd0, control_wready}, 32'd0);
        tick(); tick();
        chk("w_first_no_early_strobe", {31'd0, reg_wr_en}, 32'd0);
        control_awaddr = 8'h04; control_awvalid = 1'b1;
        tick();
        control_awvalid = 1'b0;
        chk("w_first_strobe", {reg_wr_en, reg_wr_idx, reg_wr_data[24:0]}, {1'b1, 6'd1, 25'h11});
        control_bready = 1'b1;
        tick();
        control_bready = 1'b0;
        tick();
        chk("w_first_strobe_count", wr_strobes - snap, 32'd1);

        // Read 0x0C, user data arrives the cycle after the strobe
        control_araddr = 8'h0C; control_arvalid = 1'b1;
        #1;
        chk("rd_arready", {31'd0, control_arready}, 32'd1);
        tick();
        control_arvalid = 1'b0;
        reg_rd_data = 32'h0BAD0BAD;
        chk("rd_strobe", {25'd0, reg_rd_en, reg_rd_idx}, {25'd0, 1'b1, 6'd3});
        tick();
        reg_rd_data = 32'h12345678;
        chk("rd_no_early_rvalid", {30'd0, control_rvalid, reg_rd_en}, 32'd0);
        tick();
        reg_rd_data = 32'hFFFF0000;
        chk("rd_rvalid_3cyc", {31'd0, control_rvalid}, 32'd1);
        chk("rd_rdata", control_rdata, 32'h12345678);
        chk("rd_rresp", {30'd0, control_rresp}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_stall_stable", {control_rdata[30:0], control_rvalid}, {31'h12345678, 1'b1});
        end
        control_rready = 1'b1;
        tick();
        control_rready = 1'b0;
        chk("rd_done", {30'd0, control_rvalid, control_arready}, 32'd1);

        // B backpressure blocks a second AW
        control_awaddr = 8'h00; control_awvalid = 1'b1;
        control_wdata = 32'h000000A5; control_wvalid = 1'b1;
        tick();
        control_wvalid = 1'b0;
        control_awaddr = 8'h08;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {29'd0, control_bvalid, control_awready, control_wready}, 32'd4);
            tick();
        end
        control_bready = 1'b1;
        tick();
        control_bready = 1'b0;
        chk("bp_aw_after_b", {30'd0, control_bvalid, control_awready}, 32'd1);
        tick();
        control_awvalid = 1'b0;
        control_wdata = 32'h00000077; control_wvalid = 1'b1;
        tick();
        control_wvalid = 1'b0;
        chk("bp_second_write", {reg_wr_en, reg_wr_idx, reg_wr_data[24:0]}, {1'b1, 6'd2, 25'h77});
        control_bready = 1'b1;
        tick();
        control_bready = 1'b0;

        // Out-of-range index 16 (NUM_REGS=4)
        snap = wr_strobes;
        control_awaddr = 8'h40; control_awvalid = 1'b1;
        control_wdata = 32'h0000CAFE; control_wvalid = 1'b1;
        tick();
        control_awvalid = 1'b0; control_wvalid = 1'b0;
        chk("oor_wr_en", {31'd0, reg_wr_en}, SLV ? 32'd0 : 32'd1);
        chk("oor_bresp", {29'd0, control_bvalid, control_bresp}, SLV ? 32'h6 : 32'h4);
`ifndef AXIL_RESP_SLVERR_EN
        chk("oor_wr_idx", {26'd0, reg_wr_idx}, 32'd16);
`endif
        control_bready = 1'b1;
        tick();
        control_bready = 1'b0;
        chk("oor_wr_strobe_count", wr_strobes - snap, SLV ? 32'd0 : 32'd1);

        snap = rd_strobes;
        control_araddr = 8'h40; control_arvalid = 1'b1;
        tick();
        control_arvalid = 1'b0;
        chk("oor_rd_en", {31'd0, reg_rd_en}, SLV ? 32'd0 : 32'd1);
`ifndef AXIL_RESP_SLVERR_EN
        chk("oor_rd_idx", {26'd0, reg_rd_idx}, 32'd16);
`endif
        tick();
        reg_rd_data = 32'h55AA55AA;
        tick();
        chk("oor_rvalid_rresp", {29'd0, control_rvalid, control_rresp}, SLV ? 32'h6 : 32'h4);
        chk("oor_rdata", control_rdata, SLV ? 32'd0 : 32'h55AA55AA);
        control_rready = 1'b1;
        tick();
        control_rready = 1'b0;
        chk("oor_rd_strobe_count", rd_strobes - snap, SLV ? 32'd0 : 32'd1);

        // Reset the cycle after an AR handshake
        snap = rd_strobes;
        control_araddr = 8'h04; control_arvalid = 1'b1;
        tick();
        control_arvalid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_no_rd_en", {30'd0, reg_rd_en, control_arready}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("abort_arready_after", {31'd0, control_arready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_rvalid", {31'd0, control_rvalid}, 32'd0);
        end
        chk("abort_rd_strobe_count", rd_strobes - snap, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axil_reg_responder.md
AXIL_REG_RESPONDER -- requirements
Module: axil_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning byte-address width of the control port.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning number of 32-bit word registers decoded; legal values are 1 to 2^(ADDR_W-2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports control_awaddr in ADDR_W, control_awvalid in 1 and control_awready out 1, forming the write-address channel.
REQ-006 SHALL have ports control_wdata in 32, control_wvalid in 1 and control_wready out 1, forming the write-data channel.
REQ-007 SHALL have ports control_bresp out 2, control_bvalid out 1 and control_bready in 1, forming the write-response channel.
REQ-008 SHALL have ports control_araddr in ADDR_W, control_arvalid in 1 and control_arready out 1, forming the read-address channel.
REQ-009 SHALL have ports control_rdata out 32, control_rresp out 2, control_rvalid out 1 and control_rready in 1, forming the read-data channel.
REQ-010 SHALL have ports reg_wr_en out 1, reg_wr_idx out ADDR_W-2 and reg_wr_data out 32, forming the one-cycle write strobe to user logic.
REQ-011 SHALL have ports reg_rd_en out 1, reg_rd_idx out ADDR_W-2 and reg_rd_data in 32, forming the read strobe; user logic returns reg_rd_data exactly 1 cycle after reg_rd_en.

Function
REQ-012 SHALL compute the word index as addr[ADDR_W-1:2] and ignore addr[1:0].
REQ-013 SHALL accept AW and W independently, in either order or in the same cycle; each channel is captured on its valid&&ready cycle.
REQ-014 SHALL drive awready high only while no address is held and bvalid is low; wready follows the same rule for data.
REQ-015 SHALL pulse reg_wr_en for one cycle with the held index and data in the cycle after both AW and W are held.
REQ-016 SHALL assert bvalid in the same cycle as that reg_wr_en pulse, hold bvalid and bresp until the bvalid&&bready handshake, then clear both held flags.
REQ-017 SHALL use a read FSM with states IDLE (arready=1), STROBE (reg_rd_en=1 for 1 cycle), CAPTURE (latch reg_rd_data) and RESP (rvalid=1).
REQ-018 SHALL follow the read transitions IDLE->STROBE on arvalid, STROBE->CAPTURE, CAPTURE->RESP, and RESP->IDLE on rready, giving a latency of 3 cycles from the AR handshake to the first cycle of rvalid.
REQ-019 SHALL hold rdata and rresp stable while rvalid is high and rready is low.
REQ-020 SHALL run the read and write paths concurrently; reg_wr_en and reg_rd_en in the same cycle are legal, including to the same index.
REQ-021 SHALL return OKAY (2'b00) for bresp and rresp except where REQ-027 applies.

Reset
REQ-022 SHALL, while reset is high, drive every ready, valid and strobe output to 0, drive bresp, rresp, rdata, reg_wr_idx, reg_wr_data and reg_rd_idx to 0, put the read FSM in IDLE and clear both held flags.
REQ-023 SHALL raise awready, wready and arready in the first cycle after reset falls.
REQ-024 SHALL abort any in-flight transaction when reset is asserted, with no strobe and no response issued afterwards for it.

Configuration
REQ-025 SHALL support the macro AXIL_RESP_SLVERR_EN, which enables decode-error reporting.
REQ-026 SHALL, with AXIL_RESP_SLVERR_EN undefined, decode the index modulo 2^(ADDR_W-2), always strobe, and always respond OKAY.
REQ-027 SHALL, with AXIL_RESP_SLVERR_EN defined, treat index >= NUM_REGS as a decode error: no reg_wr_en or reg_rd_en pulse, SLVERR (2'b10) response, rdata = 0, and unchanged handshake timing.

Verification
REQ-028 SHALL verify: AW and W in the same cycle, addr 0x08, data 0xDEADBEEF -> reg_wr_en pulse next cycle with idx=2 and data=0xDEADBEEF; bvalid in the same cycle with bresp=00.
REQ-029 SHALL verify: W presented 3 cycles before AW, addr 0x04 -> wready drops after W is accepted and the strobe fires only the cycle after AW is accepted; exactly 1 strobe.
REQ-030 SHALL verify: read of addr 0x0C with user returning 0x12345678 -> reg_rd_en with idx=3, then rvalid 3 cycles after the AR handshake with rdata=0x12345678; with rready held low for 5 cycles, rdata stays stable.
REQ-031 SHALL verify: bready held low for 10 cycles -> bvalid held, awready and wready low, and a second AW not accepted until the B handshake completes.
REQ-032 SHALL verify: with NUM_REGS=4 and AXIL_RESP_SLVERR_EN defined, write and read to addr 0x40 -> no strobes, bresp=10, rresp=10, rdata=0; with the macro undefined -> strobes with idx=16 and OKAY responses.
REQ-033 SHALL verify: reset asserted the cycle after an AR handshake -> no reg_rd_en and no rvalid afterwards, and arready=1 in the first cycle after reset falls.
